// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Operation codes follow the RV32M funct3 field.
package muldiv_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH);

    typedef enum logic [2:0] {
        F_MUL    = 3'b000,
        F_MULH   = 3'b001,
        F_MULHSU = 3'b010,
        F_MULHU  = 3'b011,
        F_DIV    = 3'b100,
        F_DIVU   = 3'b101,
        F_REM    = 3'b110,
        F_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic [WIDTH-1:0] neg_if(
        input logic             neg,
        input logic [WIDTH-1:0] v
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the execute stage and the muldiv unit.
// master = pipeline side, slave = muldiv unit.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [4:0]       rd_addr_i;
    logic             flush;
    logic             ready_o;
    logic             stall_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic [4:0]       rd_addr_o;

    modport master (
        output start, funct3, op1, op2, rd_addr_i, flush,
        input  ready_o, stall_o, valid_o, result_o, rd_addr_o
    );

    modport slave (
        input  start, funct3, op1, op2, rd_addr_i, flush,
        output ready_o, stall_o, valid_o, result_o, rd_addr_o
    );

endinterface

// File: rtl/muldiv_iter_dp.sv
// Bit-serial datapath: shift-add multiply or restoring divide,
// one bit per step, on unsigned magnitudes.
module muldiv_iter_dp
    import muldiv_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    // mul: hi:lo = product, lo starts as multiplier
    // div: hi = remainder, lo = dividend shifting into quotient
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic             div_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;

    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shl  = {hi_q, lo_q[WIDTH-1]};
        diff = shl - {1'b0, b_q};
        if (div_q) begin
            hi_nxt = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= is_div ? a : b;
            b_q   <= is_div ? b : a;
            div_q <= is_div;
        end else if (step) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: FSM, iteration counter,
// special-case early exit and sign fix-up around muldiv_iter_dp.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       f_q;
    logic             neg_q;
    logic [4:0]       rd_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       rd_out_q;

    logic [2:0]       f;
    logic             sgn_a, sgn_b;
    logic             neg_a, neg_b, neg_in;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             div0, ovf, special;
    logic [WIDTH-1:0] spec_res;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_fin;
    logic             load, step;

    always_comb begin
        f      = bus.funct3;
        sgn_a  = (f == F_MULH) || (f == F_MULHSU) ||
                 (f == F_DIV)  || (f == F_REM);
        sgn_b  = (f == F_MULH) || (f == F_DIV) || (f == F_REM);
        neg_a  = sgn_a & bus.op1[WIDTH-1];
        neg_b  = sgn_b & bus.op2[WIDTH-1];
        // remainder takes the dividend's sign
        neg_in = (f == F_REM) ? neg_a : (neg_a ^ neg_b);
        abs_a  = neg_if(neg_a, bus.op1);
        abs_b  = neg_if(neg_b, bus.op2);
        div0   = f[2] && (bus.op2 == '0);
        ovf    = ((f == F_DIV) || (f == F_REM)) &&
                 (bus.op1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (bus.op2 == '1);
        special = div0 | ovf;
        if (div0)
            spec_res = f[1] ? bus.op1 : '1;
        else
            spec_res = f[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    always_comb begin
        prod    = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        res_fin = '0;
        unique case (1'b1)
            f_q[2] &  f_q[1]: res_fin = neg_if(neg_q, hi_nxt);
            f_q[2] & ~f_q[1]: res_fin = neg_if(neg_q, lo_nxt);
            f_q == F_MUL:     res_fin = prod[WIDTH-1:0];
            default:          res_fin = prod[2*WIDTH-1:WIDTH];
        endcase
    end

    assign load = (state == S_IDLE) & bus.start & ~bus.flush & ~special;
    assign step = (state == S_BUSY);

    muldiv_iter_dp u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (f[2]),
        .a      (abs_a),
        .b      (abs_b),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            f_q      <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (bus.flush) begin
            state    <= S_IDLE;
            valid_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        f_q   <= f;
                        neg_q <= neg_in;
                        rd_q  <= bus.rd_addr_i;
                        cnt   <= '0;
                        if (special) begin
                            state    <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= spec_res;
                            rd_out_q <= bus.rd_addr_i;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        state    <= S_DONE;
                        valid_q  <= 1'b1;
                        result_q <= res_fin;
                        rd_out_q <= rd_q;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o   = (state == S_IDLE);
    assign bus.stall_o   = ((state == S_IDLE) & bus.start) |
                           (state == S_BUSY);
    assign bus.valid_o   = valid_q;
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed RV32M cases, random
// operations against an arithmetic model, flush and reset behaviour.
module tb_muldiv_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_special(input logic [2:0] f,
                                        input logic [31:0] a, b);
        return f[2] && (b == 32'h0 ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f,
                                            input logic [31:0] a, b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, b,
                          input logic [4:0] rd, input logic [31:0] exp);
        int          lat, vcyc, seen;
        logic        ok;
        logic [31:0] res;
        logic [4:0]  rdo;
        lat = is_special(f, a, b) ? 1 : 33;
        bus.start     = 1'b1;
        bus.funct3    = f;
        bus.op1       = a;
        bus.op2       = b;
        bus.rd_addr_i = rd;
        @(negedge clk);
        ok = bus.ready_o & bus.stall_o & ~bus.valid_o;
        next_cycle();
        bus.start     = 1'b0;
        bus.op1       = $urandom;
        bus.op2       = $urandom;
        bus.rd_addr_i = 5'($urandom);
        bus.funct3    = 3'($urandom);
        vcyc = -1;
        seen = 0;
        res  = '0;
        rdo  = '0;
        for (int c = 1; c <= lat + 3; c++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                seen++;
                if (vcyc < 0) begin
                    vcyc = c;
                    res  = bus.result_o;
                    rdo  = bus.rd_addr_o;
                end
            end
            if (c < lat && (!bus.stall_o || bus.ready_o)) ok = 1'b0;
            if (c == lat && (bus.stall_o || bus.ready_o)) ok = 1'b0;
            if (c > lat && !bus.ready_o) ok = 1'b0;
            next_cycle();
        end
        chk({tag, "/cycle"}, 64'(vcyc), 64'(lat));
        chk({tag, "/once"}, 64'(seen), 64'd1);
        chk({tag, "/result"}, 64'(res), 64'(exp));
        chk({tag, "/rd"}, 64'(rdo), 64'(rd));
        chk({tag, "/handshake"}, 64'(ok), 64'd1);
    endtask

    initial begin
        int          seen;
        logic [2:0]  f;
        logic [31:0] a, b;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.funct3    = '0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.rd_addr_i = '0;
        repeat (2) @(negedge clk);
        chk("rst/ready", 64'(bus.ready_o), 64'd1);
        chk("rst/valid", 64'(bus.valid_o), 64'd0);
        chk("rst/result", 64'(bus.result_o), 64'd0);
        chk("rst/rd", 64'(bus.rd_addr_o), 64'd0);
        chk("rst/stall0", 64'(bus.stall_o), 64'd0);
        bus.start = 1'b1;
        #1;
        chk("rst/stall1", 64'(bus.stall_o), 64'd1);
        bus.start = 1'b0;
        #1 reset = 1'b0;
        next_cycle();

        run_op("mul7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
        run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2);
        run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
        run_op("rem0", 3'd6, 32'd7, 32'd0, 5'd12, 32'd7);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b,
                   5'($urandom_range(1, 31)), ref_res(f, a, b));
        end

        // flush a divide in its cycle 10
        bus.start     = 1'b1;
        bus.funct3    = 3'd4;
        bus.op1       = 32'd1000;
        bus.op2       = 32'd3;
        bus.rd_addr_i = 5'd7;
        next_cycle();
        bus.start = 1'b0;
        repeat (9) next_cycle();
        bus.flush = 1'b1;
        seen = 0;
        @(negedge clk);
        if (bus.valid_o) seen++;
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush/ready", 64'(bus.ready_o), 64'd1);
        chk("flush/stall", 64'(bus.stall_o), 64'd0);
        for (int c = 0; c < 40; c++) begin
            if (bus.valid_o) seen++;
            @(negedge clk);
        end
        chk("flush/novalid", 64'(seen), 64'd0);
        next_cycle();
        run_op("mul3x4", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12);

        // async reset in cycle 15 of a multiply
        bus.start     = 1'b1;
        bus.funct3    = 3'd0;
        bus.op1       = 32'd1234;
        bus.op2       = 32'd5678;
        bus.rd_addr_i = 5'd22;
        next_cycle();
        bus.start = 1'b0;
        repeat (14) next_cycle();
        #2 reset = 1'b1;
        #1;
        chk("arst/valid", 64'(bus.valid_o), 64'd0);
        chk("arst/result", 64'(bus.result_o), 64'd0);
        chk("arst/rd", 64'(bus.rd_addr_o), 64'd0);
        chk("arst/ready", 64'(bus.ready_o), 64'd1);
        #1 reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        chk("arst/novalid", 64'(seen), 64'd0);
        next_cycle();

        // start held through BUSY and DONE yields one result
        bus.start     = 1'b1;
        bus.funct3    = 3'd0;
        bus.op1       = 32'd5;
        bus.op2       = 32'd6;
        bus.rd_addr_i = 5'd9;
        next_cycle();
        seen = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                seen++;
                chk("hold/result", 64'(bus.result_o), 64'd30);
            end
            next_cycle();
            if (seen != 0) bus.start = 1'b0;
        end
        chk("hold/once", 64'(seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
